// File: rtl/alarm_trigger_if.sv
// alarm_trigger_if: time buses, user controls and buzzer/status outputs of the alarm trigger
interface alarm_trigger_if;
    logic        i_Alarm_Enable;
    logic        i_Snooze;
    logic        i_Dismiss;
    logic [31:0] i_Current_Time;
    logic        i_Current_PM;
    logic [31:0] i_Alarm_Time;
    logic        i_Alarm_PM;
    logic        o_Buzzer;
    logic        o_Ringing;
    logic        o_Snoozing;
    logic [1:0]  o_State;
    modport master (
        output i_Alarm_Enable, i_Snooze, i_Dismiss, i_Current_Time, i_Current_PM, i_Alarm_Time, i_Alarm_PM,
        input  o_Buzzer, o_Ringing, o_Snoozing, o_State
    );
    modport slave (
        input  i_Alarm_Enable, i_Snooze, i_Dismiss, i_Current_Time, i_Current_PM, i_Alarm_Time, i_Alarm_PM,
        output o_Buzzer, o_Ringing, o_Snoozing, o_State
    );
endinterface

// File: rtl/alarm_trigger.sv
// alarm_trigger: HH:MM/PM match detector with ring/snooze/idle FSM and square-wave buzzer; ALARM_BEEP_PATTERN_EN gates the tone into on/off beeps
module alarm_trigger #(
    parameter int SNOOZE_MINUTES       = 9,
    parameter int RING_TIMEOUT_MINUTES = 5,
    parameter int TONE_HALF_PERIOD     = 2500,
    parameter int BEEP_HALF_PERIOD     = 2500000
) (
    input logic            i_Clk_5MHz,
    input logic            i_Reset_n,
    alarm_trigger_if.slave bus
);
    localparam int TW = $clog2(TONE_HALF_PERIOD + 1);
    typedef enum logic [1:0] {IDLE = 2'b00, RINGING = 2'b01, SNOOZE = 2'b10} state_t;
    state_t        state_q, state_d;
    logic          eq, eq_q, match_rise, tick, in_ring, enter_ring;
    logic [3:0]    min_q, ring_cnt_q, ring_cnt_d, snooze_cnt_q, snooze_cnt_d;
    logic [TW-1:0] tone_cnt_q, tone_cnt_d;
    logic          tone_q, tone_d, tone_wrap, buzz_q, buzz_d, ringing_q, snoozing_q;
    logic          unused_bits;
    assign unused_bits = ^{bus.i_Current_Time[15:0], bus.i_Alarm_Time[15:0]};
    assign eq         = (bus.i_Current_Time[31:16] == bus.i_Alarm_Time[31:16]) && (bus.i_Current_PM == bus.i_Alarm_PM);
    assign match_rise = eq && !eq_q;
    assign tick       = bus.i_Current_Time[19:16] != min_q;
    // Next state and minute counters; dismiss beats snooze, snooze swallows a coincident tick
    always_comb begin
        state_d      = state_q;
        ring_cnt_d   = ring_cnt_q;
        snooze_cnt_d = snooze_cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.i_Alarm_Enable && match_rise) begin
                    state_d    = RINGING;
                    ring_cnt_d = '0;
                end
            end
            RINGING: begin
                if (!bus.i_Alarm_Enable || bus.i_Dismiss) begin
                    state_d = IDLE;
                end else if (bus.i_Snooze) begin
                    state_d      = SNOOZE;
                    snooze_cnt_d = 4'(SNOOZE_MINUTES);
                end else if (tick) begin
                    ring_cnt_d = ring_cnt_q + 4'd1;
                    state_d    = (ring_cnt_d == 4'(RING_TIMEOUT_MINUTES)) ? IDLE : RINGING;
                end
            end
            SNOOZE: begin
                if (!bus.i_Alarm_Enable || bus.i_Dismiss) begin
                    state_d = IDLE;
                end else if (tick) begin
                    snooze_cnt_d = snooze_cnt_q - 4'd1;
                    if (snooze_cnt_d == 4'd0) begin
                        state_d    = RINGING;
                        ring_cnt_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
    assign in_ring    = state_d == RINGING;
    assign enter_ring = in_ring && (state_q != RINGING);
    assign tone_wrap  = tone_cnt_q == TW'(TONE_HALF_PERIOD - 1);
    assign tone_cnt_d = (in_ring && !enter_ring && !tone_wrap) ? tone_cnt_q + 1'b1 : '0;
    assign tone_d     = (in_ring && !enter_ring) ? tone_q ^ tone_wrap : 1'b0;
`ifdef ALARM_BEEP_PATTERN_EN
    localparam int BW = $clog2(BEEP_HALF_PERIOD + 1);
    logic [BW-1:0] beep_cnt_q, beep_cnt_d;
    logic          beep_q, beep_d, beep_wrap;
    assign beep_wrap  = beep_cnt_q == BW'(BEEP_HALF_PERIOD - 1);
    assign beep_cnt_d = (in_ring && !enter_ring && !beep_wrap) ? beep_cnt_q + 1'b1 : '0;
    assign beep_d     = in_ring ? (enter_ring ? 1'b1 : beep_q ^ beep_wrap) : 1'b0;
    assign buzz_d     = tone_d & beep_d;
    // Beep on/off phase, restarting in the on phase at every ring entry
    always_ff @(posedge i_Clk_5MHz or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            beep_cnt_q <= '0;
            beep_q     <= 1'b0;
        end else begin
            beep_cnt_q <= beep_cnt_d;
            beep_q     <= beep_d;
        end
    end
`else
    assign buzz_d = tone_d;
`endif
    // FSM, counters and registered outputs; eq_q resets high so a reset inside the alarm minute stays quiet
    always_ff @(posedge i_Clk_5MHz or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q      <= IDLE;
            eq_q         <= 1'b1;
            min_q        <= '0;
            ring_cnt_q   <= '0;
            snooze_cnt_q <= '0;
            tone_cnt_q   <= '0;
            tone_q       <= 1'b0;
            buzz_q       <= 1'b0;
            ringing_q    <= 1'b0;
            snoozing_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            eq_q         <= eq;
            min_q        <= bus.i_Current_Time[19:16];
            ring_cnt_q   <= ring_cnt_d;
            snooze_cnt_q <= snooze_cnt_d;
            tone_cnt_q   <= tone_cnt_d;
            tone_q       <= tone_d;
            buzz_q       <= buzz_d;
            ringing_q    <= state_d == RINGING;
            snoozing_q   <= state_d == SNOOZE;
        end
    end
    assign bus.o_State    = state_q;
    assign bus.o_Buzzer   = buzz_q;
    assign bus.o_Ringing  = ringing_q;
    assign bus.o_Snoozing = snoozing_q;
endmodule

// File: tb/tb_alarm_trigger.sv
// tb_alarm_trigger: directed scenarios plus random traffic, scoreboarded against a minute/cycle-count reference model
module tb_alarm_trigger;
    localparam int SNZ = 2;
    localparam int TO  = 2;
    localparam int TH  = 4;
    localparam int BH  = 8;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int errors = 0;
    int checks = 0;
    alarm_trigger_if bus();
    alarm_trigger #(
        .SNOOZE_MINUTES(SNZ), .RING_TIMEOUT_MINUTES(TO), .TONE_HALF_PERIOD(TH), .BEEP_HALF_PERIOD(BH)
    ) dut (
        .i_Clk_5MHz(clk), .i_Reset_n(rst_n), .bus(bus)
    );
    always #5 clk = ~clk;
    // Reference model: state 0 idle, 1 ringing, 2 snoozing; buzzer derived from cycles since ring entry
    int         m_state = 0;
    bit         m_eq_prev = 1'b1;
    logic [3:0] m_min_prev = 4'd0;
    int         m_ticks = 0;
    int         m_left = 0;
    int         m_since = 0;
    logic [2:0] exp_q[$];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = 0; m_eq_prev = 1'b1; m_min_prev = 4'd0; m_ticks = 0; m_left = 0; m_since = 0;
            exp_q.delete();
        end else begin
            bit eq, rise, tick, en, buz;
            int nxt;
            eq   = (bus.i_Current_Time[31:16] == bus.i_Alarm_Time[31:16]) && (bus.i_Current_PM == bus.i_Alarm_PM);
            rise = eq && !m_eq_prev;
            tick = bus.i_Current_Time[19:16] != m_min_prev;
            en   = bus.i_Alarm_Enable;
            nxt  = m_state;
            if (m_state == 1) begin
                if (!en || bus.i_Dismiss) nxt = 0;
                else if (bus.i_Snooze) begin nxt = 2; m_left = SNZ; end
                else if (tick) begin m_ticks++; if (m_ticks == TO) nxt = 0; end
            end else if (m_state == 2) begin
                if (!en || bus.i_Dismiss) nxt = 0;
                else if (tick) begin m_left--; if (m_left == 0) nxt = 1; end
            end else if (en && rise) nxt = 1;
            if (nxt == 1 && m_state != 1) begin m_since = 0; m_ticks = 0; end
            else m_since++;
            m_state = nxt;
            m_eq_prev = eq;
            m_min_prev = bus.i_Current_Time[19:16];
            buz = (m_state == 1) && ((m_since / TH) % 2 == 1);
`ifdef ALARM_BEEP_PATTERN_EN
            buz = buz && ((m_since / BH) % 2 == 0);
`endif
            exp_q.push_back({2'(m_state), buz});
        end
    end
    // Monitor: pops one expectation per active edge and compares all outputs
    logic [2:0] e;
    always @(posedge clk) if (rst_n) begin
        #1;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: no expected entry at t=%0t", $time);
        end else begin
            e = exp_q.pop_front();
            if (bus.o_State != e[2:1] || bus.o_Buzzer != e[0] || bus.o_Ringing != (e[2:1] == 2'd1) || bus.o_Snoozing != (e[2:1] == 2'd2)) begin
                errors++;
                $display("FAIL scoreboard t=%0t: state=%0d buz=%0d ring=%0d snz=%0d, expected state=%0d buz=%0d",
                         $time, bus.o_State, bus.o_Buzzer, bus.o_Ringing, bus.o_Snoozing, e[2:1], e[0]);
            end
        end
    end
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic set_time(input logic [31:0] t, input logic pm);
        bus.i_Current_Time = t;
        bus.i_Current_PM = pm;
    endtask
    task automatic pulse(input logic s, input logic d);
        bus.i_Snooze = s;
        bus.i_Dismiss = d;
        step(1);
        bus.i_Snooze = 1'b0;
        bus.i_Dismiss = 1'b0;
    endtask
    logic [7:0] mins[4] = '{8'h29, 8'h30, 8'h31, 8'h32};
    initial begin
        bus.i_Alarm_Enable = 1'b1;
        bus.i_Snooze = 1'b0;
        bus.i_Dismiss = 1'b0;
        bus.i_Alarm_Time = 32'h0630_0000;
        bus.i_Alarm_PM = 1'b0;
        set_time(32'h0629_5999, 1'b0);
        step(3);
        chk("reset_state", bus.o_State, 0);
        chk("reset_buzzer", bus.o_Buzzer, 0);
        rst_n = 1'b1;
        step(3);
        // ring at rollover, tone timing, then timeout after two minute ticks
        set_time(32'h0630_0000, 1'b0);
        step(1);
        chk("ring_entry", bus.o_State, 1);
        chk("buz_low_at_entry", bus.o_Buzzer, 0);
        step(3);
        chk("buz_low_before_half", bus.o_Buzzer, 0);
        step(1);
        chk("buz_first_rise", bus.o_Buzzer, 1);
        set_time(32'h0631_0000, 1'b0);
        step(1);
        chk("ring_after_tick1", bus.o_State, 1);
        step(3);
        set_time(32'h0632_0000, 1'b0);
        step(1);
        chk("timeout", bus.o_State, 0);
        step(20);
        chk("no_rering_after_timeout", bus.o_State, 0);
        // dismiss inside matched minute does not re-ring
        set_time(32'h0629_5999, 1'b0);
        step(2);
        set_time(32'h0630_0000, 1'b0);
        step(1);
        chk("ring_again", bus.o_State, 1);
        step(2);
        pulse(1'b0, 1'b1);
        chk("dismiss", bus.o_State, 0);
        step(20);
        chk("no_rering_same_minute", bus.o_State, 0);
        // snooze then resume after two minute ticks
        set_time(32'h0629_5999, 1'b0);
        step(2);
        set_time(32'h0630_0000, 1'b0);
        step(6);
        pulse(1'b1, 1'b0);
        chk("snooze_state", bus.o_State, 2);
        chk("snooze_buz_low", bus.o_Buzzer, 0);
        set_time(32'h0631_0000, 1'b0);
        step(1);
        chk("snooze_after_tick1", bus.o_State, 2);
        step(3);
        set_time(32'h0632_0000, 1'b0);
        step(1);
        chk("snooze_expired", bus.o_State, 1);
        step(2);
        pulse(1'b1, 1'b1);
        chk("dismiss_beats_snooze", bus.o_State, 0);
        step(3);
        pulse(1'b1, 1'b0);
        chk("late_snooze_ignored", bus.o_State, 0);
        // PM mismatch and disabled alarm stay idle
        bus.i_Alarm_PM = 1'b1;
        set_time(32'h0629_5999, 1'b0);
        step(2);
        set_time(32'h0630_0000, 1'b0);
        step(5);
        chk("pm_mismatch_idle", bus.o_State, 0);
        bus.i_Alarm_Enable = 1'b0;
        set_time(32'h0629_5999, 1'b1);
        step(2);
        set_time(32'h0630_0000, 1'b1);
        step(5);
        chk("disabled_idle", bus.o_State, 0);
        bus.i_Alarm_Enable = 1'b1;
        step(2);
        // reset mid-ring
        set_time(32'h0629_5999, 1'b1);
        step(2);
        set_time(32'h0630_0000, 1'b1);
        step(1);
        chk("pm_ring", bus.o_State, 1);
        step(5);
        chk("buz_high_before_reset", bus.o_Buzzer, 1);
        #2 rst_n = 1'b0;
        #1 chk("reset_buz_async", bus.o_Buzzer, 0);
        chk("reset_state_async", bus.o_State, 0);
        step(2);
        rst_n = 1'b1;
        step(10);
        chk("no_ring_after_reset_in_minute", bus.o_State, 0);
        set_time(32'h0631_0000, 1'b1);
        step(2);
        set_time(32'h0630_0000, 1'b1);
        step(1);
        chk("ring_on_next_rise", bus.o_State, 1);
        // random traffic, checked by the scoreboard every cycle
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) < 8)
                set_time({8'h06, mins[$urandom_range(0, 3)], 16'h0000}, ($urandom_range(0, 9) != 0));
            if ($urandom_range(0, 99) < 2)
                bus.i_Alarm_Time = {8'h06, mins[$urandom_range(0, 3)], 16'h0000};
            bus.i_Alarm_Enable = ($urandom_range(0, 49) != 0);
            bus.i_Snooze = ($urandom_range(0, 19) == 0);
            bus.i_Dismiss = ($urandom_range(0, 59) == 0);
            step(1);
        end
        bus.i_Snooze = 1'b0;
        bus.i_Dismiss = 1'b0;
        step(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
